rnn_core_scheduler: RTL and testbench
=====================================

RNN_CORE_SCHEDULER -- requirements
Module: rnn_core_scheduler

Interface
REQ-001 Parameter NCH, default 4: number of virtual neuron channels sharing one core.
REQ-002 Parameter W, default 8: current and membrane-state width.
REQ-003 Parameter TIMEOUT, default 15: maximum WAIT cycles before abort.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 req  input  NCH  per-channel update request; requester holds it high until it sees grant.
REQ-007 cur_in  input  NCH*W  packed per-channel input current; channel i at bits [i*W +: W].
REQ-008 flush  input  1  request to zero all stored membrane states.
REQ-009 grant  output  NCH  one-hot acknowledge, high for one cycle.
REQ-010 core_valid  output  1  single-cycle issue strobe to the shared neuron core.
REQ-011 core_current  output  W  latched current of the selected channel.
REQ-012 core_state  output  W  stored membrane state of the selected channel.
REQ-013 core_done  input  1  core result strobe.
REQ-014 core_state_nxt  input  W  updated membrane state from the core.
REQ-015 core_spike  input  1  spike result from the core.
REQ-016 spike_out  output  NCH  one-cycle spike pulse on the serviced channel.
REQ-017 busy  output  1  high whenever state is not IDLE.
REQ-018 err  output  1  sticky timeout flag.

Function
REQ-019 FSM states: IDLE, ISSUE, WAIT; no other states reachable.
REQ-020 IDLE with any req bit high: select a channel round-robin starting at pointer ptr, latch its channel index and cur_in slice, go to ISSUE.
REQ-021 ISSUE (exactly one cycle): grant[ch]=1, core_valid=1, core_current=latched current, core_state=mem[ch]; go to WAIT.
REQ-022 core_current, core_state are held stable from ISSUE through the end of WAIT; zero in IDLE.
REQ-023 WAIT with core_done=1: mem[ch]<=core_state_nxt, spike_out[ch]<=core_spike for one cycle, ptr<=(ch+1) mod NCH, go to IDLE.
REQ-024 WAIT counter starts at 0 on WAIT entry; if TIMEOUT cycles elapse without core_done: err<=1, mem unchanged, no spike, ptr<=(ch+1) mod NCH, go to IDLE.
REQ-025 core_done outside WAIT is ignored; it does not alter mem, spike_out or err.
REQ-026 core_done on the same cycle the timeout fires: core_done wins, no err.
REQ-027 Latency: req sampled in IDLE at cycle N -> grant/core_valid at N+1; core_done at cycle M -> spike_out and mem update visible at M+1; minimum request-to-request period 3 cycles.
REQ-028 Round-robin: channel ptr has highest priority, then ptr+1, ... wrapping; with all req high, services occur in order 0,1,2,3,0 from reset.
REQ-029 flush sampled in IDLE clears all mem entries to 0 that cycle and suppresses selection that cycle; flush outside IDLE is latched as pending and applied on the first IDLE cycle, after any WAIT writeback.
REQ-030 No arithmetic on membrane state inside this block; values pass through unmodified at width W.
REQ-031 busy is a registered decode of state; err clears only on reset.

Reset
REQ-032 rst_n low at a clock edge: state=IDLE, ptr=0, all mem=0, err=0, flush-pending=0, wait counter=0.
REQ-033 Outputs during and after reset: grant=0, core_valid=0, core_current=0, core_state=0, spike_out=0, busy=0, err=0.
REQ-034 Reset mid-WAIT abandons the operation; a later core_done is ignored per REQ-025.

Structure
REQ-035 Shared package rnn_pkg holds NCH, W, TIMEOUT defaults and the FSM state enum.
REQ-036 Round-robin selection is a sub-module rr_arbiter (inputs req, ptr; outputs one-hot select and index, any-valid).

Verification
REQ-037 Single request: req=0001, cur_in[7:0]=0x20, core replies 2 cycles after core_valid with state_nxt=0x20, spike=0 -> grant=0001 at N+1, mem[0]=0x20, spike_out=0000.
REQ-038 All requests held from reset, core replies in 1 cycle with spike=1 -> grants 0001,0010,0100,1000,0001 in order, spike_out pulses on matching channel each time.
REQ-039 Core never replies after issue for channel 2 -> err=1 exactly TIMEOUT cycles after WAIT entry, mem[2] unchanged, next grant goes to channel 3 if requested.
REQ-040 core_done on timeout cycle -> mem updated, err stays 0.
REQ-041 flush asserted during WAIT of channel 1 (state_nxt=0x55) -> writeback occurs, then all mem=0 on next IDLE cycle, no grant that cycle.
REQ-042 rst_n low during WAIT, then stray core_done -> all outputs 0, mem unchanged at 0, no spike_out.

Source files
------------

// File: rtl/rnn_pkg.sv
// Shared defaults, FSM state encoding and width helper for the RNN core scheduler.
package rnn_pkg;

    localparam int unsigned NCH_DEF     = 4;
    localparam int unsigned W_DEF       = 8;
    localparam int unsigned TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // Bits needed to index n items; never less than one.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rnn_core_scheduler_rr_arbiter.sv
// Round-robin pick: the first requesting channel at or after ptr, wrapping.
module rr_arbiter
    import rnn_pkg::*;
#(
    parameter int unsigned N = NCH_DEF,
    localparam int unsigned IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  sel,
    output logic [IW-1:0] idx,
    output logic          valid
);

    int unsigned j;

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (32'(ptr) + k) % N;
            if (!valid && req[j]) begin
                valid = 1'b1;
                idx   = IW'(j);
            end
        end
    end

    assign sel = valid ? (N'(1) << idx) : '0;

endmodule

// File: rtl/rnn_core_scheduler.sv
// Time-multiplexes NCH virtual neuron channels onto one shared neuron core,
// holding each channel's membrane state locally between updates.
module rnn_core_scheduler
    import rnn_pkg::*;
#(
    parameter int unsigned NCH     = NCH_DEF,
    parameter int unsigned W       = W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH-1:0]   req,
    input  logic [NCH*W-1:0] cur_in,
    input  logic             flush,
    output logic [NCH-1:0]   grant,
    output logic             core_valid,
    output logic [W-1:0]     core_current,
    output logic [W-1:0]     core_state,
    input  logic             core_done,
    input  logic [W-1:0]     core_state_nxt,
    input  logic             core_spike,
    output logic [NCH-1:0]   spike_out,
    output logic             busy,
    output logic             err
);

    localparam int unsigned IW = idx_w(NCH);
    localparam int unsigned CW = idx_w(TIMEOUT + 1);

    state_t          state, state_nxt;
    logic [IW-1:0]   ptr, ch, ch_next;
    logic [CW-1:0]   cnt;
    logic            flush_pend;
    logic [W-1:0]    mem     [NCH];
    logic [W-1:0]    cur_arr [NCH];

    logic [NCH-1:0]  arb_sel;
    logic [IW-1:0]   arb_idx;
    logic            arb_valid;

    logic            load, writeback, timeout, do_flush;

    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            cur_arr[i] = cur_in[i*W +: W];
        end
    end

    rr_arbiter #(.N(NCH)) u_arb (
        .req   (req),
        .ptr   (ptr),
        .sel   (arb_sel),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    assign ch_next = (ch == IW'(NCH - 1)) ? '0 : ch + IW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A pending or fresh flush takes the whole IDLE cycle; selection waits a cycle.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        writeback = 1'b0;
        timeout   = 1'b0;
        do_flush  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (flush || flush_pend) begin
                    do_flush = 1'b1;
                end else if (arb_valid) begin
                    load      = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (core_done) begin
                    writeback = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    timeout   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr          <= '0;
            ch           <= '0;
            cnt          <= '0;
            flush_pend   <= 1'b0;
            grant        <= '0;
            core_valid   <= 1'b0;
            core_current <= '0;
            core_state   <= '0;
            spike_out    <= '0;
            busy         <= 1'b0;
            err          <= 1'b0;
            for (int unsigned i = 0; i < NCH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            grant      <= load ? arb_sel : '0;
            core_valid <= load;
            busy       <= (state_nxt != ST_IDLE);
            spike_out  <= '0;
            cnt        <= (state == ST_WAIT) ? cnt + CW'(1) : '0;

            if (load) begin
                ch           <= arb_idx;
                core_current <= cur_arr[arb_idx];
                core_state   <= mem[arb_idx];
            end

            if (writeback || timeout) begin
                core_current <= '0;
                core_state   <= '0;
                ptr          <= ch_next;
            end

            if (writeback) begin
                mem[ch]   <= core_state_nxt;
                spike_out <= core_spike ? (NCH'(1) << ch) : '0;
            end

            if (timeout) begin
                err <= 1'b1;
            end

            if (do_flush) begin
                flush_pend <= 1'b0;
                for (int unsigned i = 0; i < NCH; i++) begin
                    mem[i] <= '0;
                end
            end else if (flush && state != ST_IDLE) begin
                flush_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rnn_core_scheduler.sv
// Directed bench for rnn_core_scheduler with a per-cycle transaction model.
module tb_rnn_core_scheduler;

    localparam int NCH     = 4;
    localparam int W       = 8;
    localparam int TIMEOUT = 15;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NCH-1:0]   req = '0;
    logic [NCH*W-1:0] cur_in = '0;
    logic             flush = 1'b0;
    logic [NCH-1:0]   grant;
    logic             core_valid;
    logic [W-1:0]     core_current;
    logic [W-1:0]     core_state;
    logic             core_done = 1'b0;
    logic [W-1:0]     core_state_nxt = '0;
    logic             core_spike = 1'b0;
    logic [NCH-1:0]   spike_out;
    logic             busy;
    logic             err;

    rnn_core_scheduler #(.NCH(NCH), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req            (req),
        .cur_in         (cur_in),
        .flush          (flush),
        .grant          (grant),
        .core_valid     (core_valid),
        .core_current   (core_current),
        .core_state     (core_state),
        .core_done      (core_done),
        .core_state_nxt (core_state_nxt),
        .core_spike     (core_spike),
        .spike_out      (spike_out),
        .busy           (busy),
        .err            (err)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Model: one channel in service at a time, tracked by how long it has been out.
    int             m_ch = -1;
    int             m_age = 0;
    int             m_ptr = 0;
    bit             m_fpend = 0;
    bit             m_err = 0;
    logic [W-1:0]   m_mem [NCH];
    bit             live = 0;
    logic [NCH-1:0] e_grant = '0, e_spike = '0;
    logic           e_valid = 0, e_busy = 0, e_err = 0;
    logic [W-1:0]   e_cur = '0, e_state = '0;

    function automatic int rr_pick(input logic [NCH-1:0] r, input int p);
        for (int k = 0; k < NCH; k++) begin
            if (r[(p + k) % NCH]) return (p + k) % NCH;
        end
        return -1;
    endfunction

    task automatic model_retire();
        m_ptr   = (m_ch + 1) % NCH;
        m_ch    = -1;
        e_cur   = '0;
        e_state = '0;
    endtask

    always @(posedge clk) begin
        int pick;
        if (!rst_n) begin
            m_ch = -1; m_age = 0; m_ptr = 0; m_fpend = 0; m_err = 0;
            for (int i = 0; i < NCH; i++) m_mem[i] = '0;
            e_grant = '0; e_spike = '0; e_valid = 0; e_busy = 0; e_err = 0;
            e_cur = '0; e_state = '0;
            live = 1;
        end else begin
            e_grant = '0; e_valid = 0; e_spike = '0;
            if (m_ch < 0) begin
                if (flush || m_fpend) begin
                    for (int i = 0; i < NCH; i++) m_mem[i] = '0;
                    m_fpend = 0;
                end else begin
                    pick = rr_pick(req, m_ptr);
                    if (pick >= 0) begin
                        m_ch    = pick;
                        m_age   = 0;
                        e_grant = NCH'(1) << pick;
                        e_valid = 1;
                        e_cur   = cur_in[pick*W +: W];
                        e_state = m_mem[pick];
                    end
                end
            end else begin
                if (flush) m_fpend = 1;
                if (m_age == 0) begin
                    m_age = 1;
                end else if (core_done) begin
                    m_mem[m_ch] = core_state_nxt;
                    if (core_spike) e_spike = NCH'(1) << m_ch;
                    model_retire();
                end else if (m_age == TIMEOUT) begin
                    m_err = 1;
                    model_retire();
                end else begin
                    m_age++;
                end
            end
            e_err  = m_err;
            e_busy = (m_ch >= 0);
        end
    end

    always @(negedge clk) begin
        if (live) begin
            check("grant", 32'(grant), 32'(e_grant));
            check("core_valid", 32'(core_valid), 32'(e_valid));
            check("core_current", 32'(core_current), 32'(e_cur));
            check("core_state", 32'(core_state), 32'(e_state));
            check("spike_out", 32'(spike_out), 32'(e_spike));
            check("busy", 32'(busy), 32'(e_busy));
            check("err", 32'(err), 32'(e_err));
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; req = '0; flush = 1'b0; core_done = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Returns at the negedge of the issue cycle.
    task automatic await_valid(input string nm);
        bit ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (core_valid === 1'b1) begin
                ok = 1;
                break;
            end
        end
        check({nm, "_issue_seen"}, 32'(ok), 32'd1);
    endtask

    // From the issue-cycle negedge: core_done high during issue cycle + d.
    task automatic reply(input int d, input logic [W-1:0] nxt, input logic spk);
        repeat (d) @(posedge clk);
        #1;
        core_done = 1'b1; core_state_nxt = nxt; core_spike = spk;
        @(posedge clk); #1;
        core_done = 1'b0; core_spike = 1'b0;
    endtask

    logic [NCH-1:0] exp_g [5];

    initial begin
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
        exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);

        // Single request, reply two cycles after issue
        req = 4'b0001; cur_in = 32'h0000_0020;
        await_valid("t1");
        check("t1_grant", 32'(grant), 32'h1);
        check("t1_cur", 32'(core_current), 32'h20);
        check("t1_state", 32'(core_state), 32'h0);
        req = '0;
        reply(2, 8'h20, 1'b0);
        @(negedge clk);
        check("t1_spike", 32'(spike_out), 32'h0);
        check("t1_model_mem0", 32'(m_mem[0]), 32'h20);
        req = 4'b0001; cur_in = 32'h0000_0005;
        await_valid("t1b");
        check("t1_state_back", 32'(core_state), 32'h20);
        req = '0;
        reply(1, 8'h21, 1'b0);

        // All requests held from reset, fast spiking replies
        do_reset();
        req = 4'b1111; cur_in = 32'h4433_2211;
        for (int i = 0; i < 5; i++) begin
            await_valid("t2");
            check("t2_grant", 32'(grant), 32'(exp_g[i]));
            reply(1, 8'(i + 1), 1'b1);
            @(negedge clk);
            check("t2_spike", 32'(spike_out), 32'(exp_g[i]));
        end
        req = '0;

        // Timeout on channel 2, pointer then moves to channel 3
        do_reset();
        req = 4'b0100; cur_in = 32'h0000_0000;
        await_valid("t3a"); req = '0; reply(1, 8'h33, 1'b0);
        req = 4'b1000;
        await_valid("t3b"); req = '0; reply(1, 8'h10, 1'b0);
        req = 4'b0100;
        await_valid("t3c");
        check("t3_grant2", 32'(grant), 32'h4);
        req = 4'b1001;
        for (int i = 1; i <= TIMEOUT; i++) begin
            @(negedge clk);
            check("t3_err_early", 32'(err), 32'd0);
        end
        @(negedge clk);
        check("t3_err_set", 32'(err), 32'd1);
        await_valid("t3d");
        check("t3_next_ch3", 32'(grant), 32'h8);
        req = 4'b0001; reply(1, 8'h12, 1'b0);
        await_valid("t3e"); req = '0; reply(1, 8'h13, 1'b0);
        req = 4'b0100;
        await_valid("t3f");
        check("t3_mem2_kept", 32'(core_state), 32'h33);
        req = '0; reply(1, 8'h34, 1'b0);

        // core_done on the last WAIT cycle wins over timeout
        do_reset();
        req = 4'b0001; cur_in = 32'h0000_0007;
        await_valid("t4"); req = '0;
        reply(TIMEOUT, 8'h77, 1'b1);
        @(negedge clk);
        check("t4_err", 32'(err), 32'd0);
        check("t4_spike", 32'(spike_out), 32'h1);
        req = 4'b0001;
        await_valid("t4b");
        check("t4_mem0", 32'(core_state), 32'h77);
        req = '0; reply(1, 8'h78, 1'b0);

        // Flush during WAIT of channel 1: writeback first, then clear
        do_reset();
        req = 4'b0001; cur_in = 32'h0000_0011;
        await_valid("t5a"); req = '0; reply(1, 8'h11, 1'b0);
        req = 4'b0010;
        await_valid("t5b"); req = '0;
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        core_done = 1'b1; core_state_nxt = 8'h55; core_spike = 1'b0; req = 4'b0001;
        @(posedge clk); #1 core_done = 1'b0;
        @(negedge clk);
        check("t5_wb_idle_grant", 32'(grant), 32'h0);
        @(negedge clk);
        check("t5_flush_cycle_grant", 32'(grant), 32'h0);
        @(negedge clk);
        check("t5_grant_after", 32'(grant), 32'h1);
        check("t5_mem0_zero", 32'(core_state), 32'h0);
        req = '0; reply(1, 8'h01, 1'b0);
        req = 4'b0010;
        await_valid("t5c");
        check("t5_mem1_zero", 32'(core_state), 32'h0);
        req = '0; reply(1, 8'h02, 1'b0);

        // Reset mid-WAIT, then a stray core_done
        do_reset();
        req = 4'b0001; cur_in = 32'h0000_0044;
        await_valid("t6"); req = '0;
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        core_done = 1'b1; core_state_nxt = 8'h99; core_spike = 1'b1;
        @(posedge clk); #1 core_done = 1'b0; core_spike = 1'b0;
        @(negedge clk);
        check("t6_spike", 32'(spike_out), 32'h0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_state", 32'(core_state), 32'h0);
        req = 4'b0001;
        await_valid("t6b");
        check("t6_mem0", 32'(core_state), 32'h0);
        req = '0; reply(1, 8'h03, 1'b0);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
